// File: rtl/game_pkg.sv
// Shared types and constants for the game round flow controller.
package game_pkg;

  typedef enum logic [1:0] {
    ST_COUNTDOWN = 2'b00,
    ST_PLAY      = 2'b01,
    ST_OVER      = 2'b10
  } game_state_t;

  localparam logic [1:0] OVER_NONE  = 2'b00;
  localparam logic [1:0] OVER_TOM   = 2'b01;
  localparam logic [1:0] OVER_JERRY = 2'b10;

  localparam int FRAMES_PER_SEC_DEF = 60;
  localparam int COUNTDOWN_SEC_DEF  = 3;
  localparam int ROUND_SEC_DEF      = 90;

  // A catch outranks cheese when both win conditions fire together.
  function automatic logic [1:0] round_result(input logic [1:0] go);
    return go[0] ? OVER_TOM : OVER_JERRY;
  endfunction

endpackage

// File: rtl/game_sec_timer.sv
// Turns vsync into a registered frame tick and a once-per-second tick.
// The frame count is cleared by clr (state entry or restart).
module game_sec_timer #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic clr,
  output logic sec_tick
);

  localparam int CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_SEC - 1);

  logic          vs_q, vs_qq, tick;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      tick  <= 1'b0;
    end else begin
      vs_q  <= vsync;
      vs_qq <= vs_q;
      tick  <= vs_q & ~vs_qq;
    end
  end

  assign sec_tick = tick && (cnt == LAST);

  // clr wins over a coincident tick so every state starts a full second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (sec_tick) cnt <= '0;
    else if (tick)     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Round flow FSM: COUNTDOWN -> PLAY -> OVER, restart back to COUNTDOWN.
// Optional round time limit enabled by macro GAME_ROUND_TIMEOUT_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
  parameter int COUNTDOWN_SEC  = COUNTDOWN_SEC_DEF,
  parameter int ROUND_SEC      = ROUND_SEC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset,
  input  logic       vsync,
  input  logic [1:0] gameover,
  output logic [1:0] over,
  output logic       freeze,
  output logic [1:0] countdown,
  output logic [7:0] round_secs,
  output logic [1:0] state
);

  localparam logic [1:0] CD_INIT = 2'(COUNTDOWN_SEC);
`ifdef GAME_ROUND_TIMEOUT_EN
  localparam logic [7:0] RS_INIT = 8'(ROUND_SEC);
`else
  localparam logic [7:0] RS_INIT = 8'd0;
`endif

  game_state_t st, st_n;
  logic [1:0]  cd_n, ov_n;
  logic [7:0]  rs_n;
  logic        reset_q, restart, sec_tick, clr;

  // A held keyboard level yields a single restart on its rising edge.
  assign restart = reset & ~reset_q;
  assign clr     = restart | (st_n != st);
  assign state   = st;

  game_sec_timer #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .vsync    (vsync),
    .clr      (clr),
    .sec_tick (sec_tick)
  );

  always_comb begin
    st_n = st;
    cd_n = countdown;
    rs_n = round_secs;
    ov_n = over;
    if (restart) begin
      st_n = ST_COUNTDOWN;
      cd_n = CD_INIT;
      rs_n = RS_INIT;
      ov_n = OVER_NONE;
    end else begin
      case (st)
        ST_COUNTDOWN: if (sec_tick) begin
          if (countdown <= 2'd1) begin
            st_n = ST_PLAY;
            cd_n = 2'd0;
            rs_n = RS_INIT;
          end else begin
            cd_n = countdown - 2'd1;
          end
        end
        ST_PLAY: if (|gameover) begin
          st_n = ST_OVER;
          ov_n = round_result(gameover);
        end
`ifdef GAME_ROUND_TIMEOUT_EN
        else if (round_secs == 8'd0) begin
          st_n = ST_OVER;
          ov_n = OVER_JERRY;
        end else if (sec_tick) begin
          rs_n = round_secs - 8'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_COUNTDOWN;
      countdown  <= CD_INIT;
      round_secs <= RS_INIT;
      over       <= OVER_NONE;
      freeze     <= 1'b1;
      reset_q    <= 1'b0;
    end else begin
      st         <= st_n;
      countdown  <= cd_n;
      round_secs <= rs_n;
      over       <= ov_n;
      freeze     <= (st_n != ST_PLAY);
      reset_q    <= reset;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scenarios plus random stimulus against a behavioural round model.
module tb_game_flow_ctrl;
  localparam int FPS = 2, CDS = 3, RSS = 5;
`ifdef GAME_ROUND_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int RS_INIT = RSS;
`else
  localparam bit TO_EN = 1'b0;
  localparam int RS_INIT = 0;
`endif

  logic       clk = 1'b0, rst = 1'b1, reset = 1'b0, vsync = 1'b0;
  logic [1:0] gameover = 2'b00;
  logic [1:0] over, countdown, state;
  logic       freeze;
  logic [7:0] round_secs;
  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  game_flow_ctrl #(.FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CDS), .ROUND_SEC(RSS)) dut (
    .clk(clk), .rst(rst), .reset(reset), .vsync(vsync), .gameover(gameover),
    .over(over), .freeze(freeze), .countdown(countdown),
    .round_secs(round_secs), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: 0=countdown 1=play 2=over; frame tick lands two edges
  // after vsync is first sampled high.
  int m_st, m_cd, m_rs, m_ov, m_fr;
  bit m_vs1, m_vs2, m_tick, m_rprev;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_cd = CDS; m_rs = RS_INIT; m_ov = 0; m_fr = 0;
      m_vs1 = 0; m_vs2 = 0; m_tick = 0; m_rprev = 0;
    end else begin : step
      bit t, rs_pulse, sec;
      int prev;
      t = m_tick;
      rs_pulse = reset && !m_rprev;
      sec = t && (m_fr == FPS - 1);
      prev = m_st;
      if (rs_pulse) begin
        m_st = 0; m_cd = CDS; m_rs = RS_INIT; m_ov = 0;
      end else if (m_st == 0) begin
        if (sec) begin
          if (m_cd == 1) begin m_st = 1; m_cd = 0; m_rs = RS_INIT; end
          else m_cd = m_cd - 1;
        end
      end else if (m_st == 1) begin
        if (gameover != 0) begin m_st = 2; m_ov = gameover[0] ? 1 : 2; end
        else if (TO_EN && m_rs == 0) begin m_st = 2; m_ov = 2; end
        else if (TO_EN && sec) m_rs = m_rs - 1;
      end
      if (rs_pulse || m_st != prev) m_fr = 0;
      else if (t) m_fr = (m_fr + 1) % FPS;
      m_tick = m_vs1 && !m_vs2;
      m_vs2 = m_vs1;
      m_vs1 = vsync;
      m_rprev = reset;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("state", state, m_st);
      chk("countdown", countdown, m_cd);
      chk("round_secs", round_secs, m_rs);
      chk("over", over, m_ov);
      chk("freeze", freeze, m_st != 1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vsync = 1'b1;
      @(negedge clk);
      @(negedge clk) vsync = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic restart_hold(input int n);
    @(negedge clk) reset = 1'b1;
    idle(n - 1);
    @(negedge clk) reset = 1'b0;
    idle(2);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(1);
    chk("rst_state", state, 0);
    chk("rst_cd", countdown, CDS);
    chk("rst_freeze", freeze, 1);
    chk("rst_over", over, 0);
    chk("rst_rs", round_secs, RS_INIT);

    // countdown 3,2,1 then play
    pulses(2); idle(1); chk("cd_step2", countdown, 2);
    pulses(2); idle(1); chk("cd_step1", countdown, 1);
    pulses(2); idle(1);
    chk("play_state", state, 1); chk("play_freeze", freeze, 0); chk("play_cd", countdown, 0);

    // Tom wins; later cheese ignored
    @(negedge clk) gameover = 2'b01;
    @(negedge clk) gameover = 2'b00;
    idle(1);
    chk("tom_over", over, 1); chk("tom_state", state, 2); chk("tom_freeze", freeze, 1);
    @(negedge clk) gameover = 2'b10;
    @(negedge clk) gameover = 2'b00;
    idle(2); chk("over_hold", over, 1);

    // held restart counts once
    restart_hold(4);
    chk("rs_state", state, 0); chk("rs_cd", countdown, CDS); chk("rs_over", over, 0);

    // both win bits -> Tom
    pulses(6); idle(1);
    @(negedge clk) gameover = 2'b11;
    @(negedge clk) gameover = 2'b00;
    idle(1); chk("both_over", over, 1);

    // round timeout
    restart_hold(2);
    pulses(6); idle(1);
    chk("to_play_rs", round_secs, RS_INIT);
    if (TO_EN) begin
      pulses(10); idle(3);
      chk("to_state", state, 2); chk("to_over", over, 2); chk("to_rs", round_secs, 0);
    end else begin
      pulses(20); idle(3);
      chk("noto_state", state, 1); chk("noto_rs", round_secs, 0);
    end

    // restart beats gameover in the same cycle
    restart_hold(2);
    pulses(6); idle(1);
    @(negedge clk) begin reset = 1'b1; gameover = 2'b01; end
    @(negedge clk) begin reset = 1'b0; gameover = 2'b00; end
    idle(1);
    chk("race_over", over, 0); chk("race_state", state, 0);

    // asynchronous rst in play
    pulses(6); pulses(6); idle(1);
    chk("pre_rst_state", state, 1);
    chk("pre_rst_rs", round_secs, TO_EN ? 2 : 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 0); chk("arst_cd", countdown, CDS);
    chk("arst_freeze", freeze, 1); chk("arst_over", over, 0);
    chk("arst_rs", round_secs, RS_INIT);
    @(negedge clk); @(negedge clk) rst = 1'b0;
    idle(2);

    // random traffic
    repeat (4000) begin
      @(negedge clk);
      vsync    = ($urandom % 3) == 0;
      reset    = ($urandom % 120) == 0;
      gameover = (($urandom % 90) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
    @(negedge clk) begin vsync = 1'b0; reset = 1'b0; gameover = 2'b00; end
    idle(4);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, vsync rising edges per game second.
REQ-002 Parameter COUNTDOWN_SEC, default 3, pre-round countdown length in seconds (range 1..3).
REQ-003 Parameter ROUND_SEC, default 90, round time limit in seconds (range 1..255).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  pixel clock shared with the VGA pipeline.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 reset  input  1  keyboard restart request, synchronous to clk; a level held for several cycles counts as one request.
REQ-008 vsync  input  1  frame sync from the VGA timing generator.
REQ-009 gameover  input  2  win detection: bit0 = Tom caught Jerry, bit1 = Jerry collected enough cheese.
REQ-010 over  output  2  round result to the movement controllers and the screen selector: 00 = none, 01 = Tom wins, 10 = Jerry wins.
REQ-011 freeze  output  1  high when the characters must not move.
REQ-012 countdown  output  2  seconds left before play; 0 outside COUNTDOWN.
REQ-013 round_secs  output  8  seconds left in the round.
REQ-014 state  output  2  current state: 00 COUNTDOWN, 01 PLAY, 10 OVER.

Function
REQ-015 Frame tick: one-cycle pulse, one cycle after a registered 0->1 transition of vsync.
REQ-016 Restart pulse: one-cycle pulse on the 0->1 transition of reset.
REQ-017 Frame counter: counts ticks 0..FRAMES_PER_SEC-1; the tick at count FRAMES_PER_SEC-1 is the second-tick and wraps the count to 0; the count clears on every state entry.
REQ-018 COUNTDOWN: freeze=1 and over=00; countdown loads COUNTDOWN_SEC and decrements on each second-tick.
REQ-019 COUNTDOWN exit: a second-tick while countdown=1 moves the state to PLAY and sets countdown=0 and round_secs=ROUND_SEC.
REQ-020 PLAY: freeze=0 and over=00; any gameover bit set moves the state to OVER on the next edge.
REQ-021 Result on entry to OVER: gameover=01 sets over=01; gameover=10 sets over=10; gameover=11 sets over=01 (a catch outranks cheese).
REQ-022 OVER: freeze=1; over holds its value; gameover is ignored; the block stays in OVER until a restart pulse.
REQ-023 A restart pulse in any state moves the state to COUNTDOWN, clears over, reloads countdown and clears the frame counter.
REQ-024 Priority in a single cycle: restart > gameover > timeout > second-tick.
REQ-025 All outputs are registered; a state change is visible on outputs one clk after the cause.
REQ-026 Counters never underflow: round_secs saturates at 0.

Reset
REQ-027 On rst: state=COUNTDOWN, countdown=COUNTDOWN_SEC, freeze=1, over=00, round_secs=ROUND_SEC, frame counter=0, edge registers=0.
REQ-028 rst asserted mid-round aborts the round with no residual result; the first post-reset cycle behaves as a fresh COUNTDOWN.

Configuration
REQ-029 Macro GAME_ROUND_TIMEOUT_EN.
- Defined: round_secs decrements on each second-tick in PLAY; reaching 0 in PLAY moves the state to OVER with over=10 (Jerry survives).
- Undefined: no timeout logic; round_secs is constant 0; PLAY ends only on gameover or restart.

Structure
REQ-030 A shared package game_pkg holds the state enum, the over encoding constants (OVER_NONE, OVER_TOM, OVER_JERRY) and the default timing constants.
REQ-031 Sub-module game_sec_timer contains the vsync edge detect, the frame counter and the second-tick generation, with a clear input.
REQ-032 The main FSM and counters are in game_flow_ctrl.

Verification (FRAMES_PER_SEC=2, COUNTDOWN_SEC=3, ROUND_SEC=5)
REQ-033 After rst release, 6 vsync pulses -> countdown steps 3,2,1; state=PLAY and freeze=0 one clk after the 6th tick.
REQ-034 In PLAY, gameover=01 for one cycle -> over=01, state=OVER, freeze=1; later gameover=10 -> over stays 01.
REQ-035 In PLAY, gameover=11 -> over=01.
REQ-036 With GAME_ROUND_TIMEOUT_EN, 10 vsync pulses in PLAY -> round_secs 5..0, then over=10; without the macro, 20 pulses -> state stays PLAY and round_secs=0.
REQ-037 In OVER, reset held 4 cycles -> one restart; state=COUNTDOWN, countdown=3, over=00; restart in the same cycle as gameover=01 -> over=00.
REQ-038 rst asserted in PLAY with round_secs=2 -> all outputs at REQ-027 values asynchronously.
